// File: rtl/wb_trace_monitor.sv
// wb_trace_monitor: stamps CPU register write-backs into a trace FIFO and flags program halt.
module wb_trace_monitor #(
  parameter int FIFO_DEPTH = 8,
  parameter int CYC_W      = 16,
  parameter int HALT_NOPS  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_s1,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  output logic              trc_valid,
  input  logic              trc_ready,
  output logic [CYC_W+36:0] trc_data,
  output logic [15:0]       wr_count,
  output logic              overflow,
  output logic              done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = CYC_W + 37;
  localparam int NW = $clog2(HALT_NOPS + 1);
  localparam logic [NW-1:0] HALT_N = NW'(HALT_NOPS);

  typedef enum logic [1:0] {RUN, COUNT, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]     wr_count_q, wr_count_d;
  logic            overflow_q, overflow_d;
  logic [NW-1:0]   nop_q, nop_d, nop_inc;
  logic [1:0]      idle_q, idle_d;
  logic [RW-1:0]   mem_q [FIFO_DEPTH];
  logic            capture, empty, full, pop, push;

  always_comb begin
    capture    = wb_en && (wb_addr != 5'd0);
    empty      = wr_ptr_q == rd_ptr_q;
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = !empty && trc_ready;
    push       = capture && (!full || pop);
    cyc_d      = cyc_q + 1'b1;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_count_d = (capture && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    overflow_d = overflow_q || (capture && full && !pop);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= RUN;
      cyc_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_count_q <= '0;
      overflow_q <= 1'b0;
      nop_q      <= '0;
      idle_q     <= '0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_count_q <= wr_count_d;
      overflow_q <= overflow_d;
      nop_q      <= nop_d;
      idle_q     <= idle_d;
    end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cyc_q, wb_addr, wb_data};

  // idle_q counts prior quiet cycles in DRAIN; the current quiet cycle makes the fourth.
  always_comb begin
    state_d = state_q;
    nop_d   = nop_q;
    idle_d  = idle_q;
    nop_inc = nop_q + 1'b1;
    case (state_q)
      RUN:
        if (instr_s1 == 32'd0) begin
          nop_d   = NW'(1);
          idle_d  = '0;
          state_d = (HALT_N <= NW'(1)) ? DRAIN : COUNT;
        end
      COUNT:
        if (instr_s1 != 32'd0) begin
          nop_d   = '0;
          state_d = RUN;
        end else begin
          nop_d   = nop_inc;
          idle_d  = '0;
          state_d = (nop_inc == HALT_N) ? DRAIN : COUNT;
        end
      DRAIN: begin
        idle_d  = wb_en ? 2'd0 : (idle_q == 2'd3 ? idle_q : idle_q + 2'd1);
        state_d = (empty && !wb_en && idle_q == 2'd3) ? DONE : DRAIN;
      end
      default: state_d = DONE;
    endcase
  end

  always_comb begin
    trc_valid = !empty;
    trc_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    wr_count  = wr_count_q;
    overflow  = overflow_q;
    done      = state_q == DONE;
  end
endmodule

// File: tb/tb_wb_trace_monitor.sv
// tb_wb_trace_monitor: random and directed stimulus checked every cycle against a queue-based model.
module tb_wb_trace_monitor;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_s1 = 32'h13;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        trc_ready = 1'b1;
  logic        trc_valid, overflow, done;
  logic [52:0] trc_data;
  logic [15:0] wr_count;

  wb_trace_monitor dut (
    .clk(clk), .reset(reset), .instr_s1(instr_s1), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_data(trc_data),
    .wr_count(wr_count), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [52:0] q[$];
  int unsigned cyc;
  int          wrc, zeros, quiet;
  bit          ovf, m_done, in_drain;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    cyc = 0; wrc = 0; zeros = 0; quiet = 0;
    ovf = 0; m_done = 0; in_drain = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs held across that edge.
  task automatic model_step();
    bit cap, pop, was_empty;
    if (reset) begin
      model_reset();
      return;
    end
    cap = wb_en && wb_addr != 5'd0;
    was_empty = q.size() == 0;
    pop = !was_empty && trc_ready;
    if (!m_done) begin
      if (in_drain) begin
        quiet = wb_en ? 0 : quiet + 1;
        if (quiet >= 4 && was_empty) m_done = 1;
      end else begin
        zeros = (instr_s1 == 32'd0) ? zeros + 1 : 0;
        if (zeros >= 5) begin
          in_drain = 1;
          quiet = 0;
        end
      end
    end
    if (pop) void'(q.pop_front());
    if (cap) begin
      if (wrc < 65535) wrc++;
      if (q.size() < 8) q.push_back({cyc[15:0], wb_addr, wb_data});
      else ovf = 1;
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    chk("valid", trc_valid, q.size() > 0);
    if (q.size() > 0) chk("data", trc_data, q[0]);
    chk("wr_count", wr_count, wrc);
    chk("overflow", overflow, ovf);
    chk("done", done, m_done);
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_in();
    wb_en = 0; wb_addr = 0; wb_data = 0; instr_s1 = 32'h13; trc_ready = 1;
  endtask

  task automatic cap_in(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_data = d;
  endtask

  task automatic do_reset();
    reset = 1;
    model_reset();
    #1;
    chk("rst_valid", trc_valid, 0);
    chk("rst_data", trc_data, 0);
    chk("rst_wr_count", wr_count, 0);
    tick();
    tick();
    reset = 0;
  endtask

  task automatic drain_count(input int budget, output int n);
    n = 0;
    for (int i = 0; i < budget; i++) begin
      if (trc_valid) begin
        chk("drain_stamp", trc_data[52:37], n);
        n++;
      end
      tick();
    end
  endtask

  initial begin
    int n, mode;
    idle_in();
    model_reset();
    @(negedge clk);
    #1;
    do_reset();

    // single write at cycle 3
    repeat (3) tick();
    cap_in(5'd8, 32'h5);
    tick();
    idle_in();
    chk("single_valid", trc_valid, 1);
    chk("single_data", trc_data, {16'd3, 5'd8, 32'h5});
    chk("single_count", wr_count, 1);
    tick();
    chk("single_gone", trc_valid, 0);

    // writes to register 0 are invisible
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cap_in(5'd0, $urandom);
      tick();
    end
    idle_in();
    chk("r0_valid", trc_valid, 0);
    chk("r0_count", wr_count, 0);

    // backpressure and overflow
    do_reset();
    trc_ready = 0;
    for (int i = 0; i < 9; i++) begin
      cap_in(5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    wb_en = 0;
    tick();
    chk("bp_overflow", overflow, 1);
    chk("bp_count", wr_count, 9);
    trc_ready = 1;
    drain_count(12, n);
    chk("bp_drained", n, 8);

    // full FIFO with simultaneous pop and push
    do_reset();
    trc_ready = 0;
    for (int i = 0; i < 8; i++) begin
      cap_in(5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    trc_ready = 1;
    for (int i = 0; i < 5; i++) begin
      cap_in(5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    idle_in();
    chk("fp_overflow", overflow, 0);
    chk("fp_count", wr_count, 13);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (trc_valid) n++;
      tick();
    end
    chk("fp_occupancy", n, 8);

    // halt detection with an interrupted zero run
    do_reset();
    instr_s1 = 0;
    repeat (4) tick();
    instr_s1 = 32'h13;
    tick();
    instr_s1 = 0;
    repeat (4) tick();
    chk("halt_early", done, 0);
    tick();
    instr_s1 = 32'h13;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("halt_done", done, k == 4);
    end
    cap_in(5'd4, 32'hABCD);
    tick();
    idle_in();
    chk("halt_capture", trc_valid, 1);
    chk("halt_sticky", done, 1);

    // reset while records are queued
    do_reset();
    trc_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cap_in(5'($urandom_range(1, 31)), $urandom);
      tick();
    end
    wb_en = 0;
    tick();
    chk("mid_queued", trc_valid, 1);
    reset = 1;
    model_reset();
    #1;
    chk("mid_valid_now", trc_valid, 0);
    tick();
    tick();
    reset = 0;
    trc_ready = 1;
    chk("mid_count", wr_count, 0);
    cap_in(5'd3, 32'h7);
    tick();
    idle_in();
    chk("mid_stamp", trc_data, {16'd0, 5'd3, 32'h7});

    // randomized traffic in phases
    do_reset();
    mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) mode = $urandom_range(0, 3);
      if (i % 1300 == 700) do_reset();
      instr_s1  = ($urandom_range(0, 9) < (mode == 2 ? 7 : 2)) ? 32'd0 : $urandom;
      wb_en     = (mode == 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      wb_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      wb_data   = $urandom;
      trc_ready = (mode == 0) ? ($urandom_range(0, 7) == 0) :
                  (mode == 3) ? 1'b1 : ($urandom_range(0, 1) == 1);
      tick();
    end
    idle_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_trace_monitor.md
WB_TRACE_MONITOR -- requirements
Module: wb_trace_monitor

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 8, giving the number of trace-record FIFO entries (power of two, at least 2).
REQ-002 The module SHALL have parameter CYC_W, default 16, giving the cycle-stamp width.
REQ-003 The module SHALL have parameter HALT_NOPS, default 5, giving the number of consecutive all-zero stage-1 instructions that declares the program finished.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port instr_s1, input, 32 bits: CPU fetch-stage instruction.
REQ-007 Port wb_en, input, 1 bit: CPU stage-5 register write enable.
REQ-008 Port wb_addr, input, 5 bits: CPU stage-5 destination register.
REQ-009 Port wb_data, input, 32 bits: CPU stage-5 write-back data.
REQ-010 Port trc_valid, output, 1 bit: a trace record is presented.
REQ-011 Port trc_ready, input, 1 bit: the consumer accepts the record.
REQ-012 Port trc_data, output, CYC_W+37 bits: the record {cycle stamp, wb_addr, wb_data}, with the stamp in the MSBs.
REQ-013 Port wr_count, output, 16 bits: count of captured register writes.
REQ-014 Port overflow, output, 1 bit: sticky flag, set when a record was dropped.
REQ-015 Port done, output, 1 bit: sticky flag, set when the program has halted.

Function
REQ-016 Cycle counter: increments by 1 every clock after reset, wraps modulo 2^CYC_W, and is 0 in the first cycle after reset release.
REQ-017 Capture condition: wb_en=1 and wb_addr!=0 on a rising edge; writes to register 0 are ignored entirely.
REQ-018 On capture with the FIFO not full, the record is pushed using the current cycle-counter value; latency from capture edge to record visible at the FIFO head (if the FIFO was empty) is 1 cycle.
REQ-019 On capture with the FIFO full and no pop in the same cycle, the record is dropped and overflow is set.
REQ-020 On capture with the FIFO full and a pop in the same cycle, the push succeeds, the occupancy is unchanged and overflow is not set.
REQ-021 wr_count increments on every capture, dropped or not, and saturates at 16'hFFFF.
REQ-022 A pop occurs when trc_valid=1 and trc_ready=1; trc_valid = FIFO not empty; trc_data = FIFO head.
REQ-023 trc_data SHALL hold stable while trc_valid=1 and trc_ready=0.
REQ-024 Read and write pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
REQ-025 Halt FSM states and transitions:
- RUN: go to COUNT when instr_s1==0.
- COUNT: holds a run counter; instr_s1!=0 returns to RUN and clears the counter; reaching HALT_NOPS consecutive zero instructions goes to DRAIN.
- DRAIN: go to DONE when the FIFO is empty and wb_en has been 0 for 4 consecutive cycles, covering pipeline flush.
- DONE: terminal until reset; done=1 only in DONE.
REQ-026 Captures continue in all FSM states, including DONE.
REQ-027 overflow and done clear only on reset.

Reset
REQ-028 While reset=1, the following SHALL hold asynchronously: trc_valid=0, trc_data=0, wr_count=0, overflow=0, done=0, FIFO empty, cycle counter=0, FSM=RUN.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents with no partial record emitted.
REQ-030 The first capture is possible on the first rising edge after reset deasserts.

Verification
REQ-031 Single write: wb_en=1, wb_addr=8, wb_data=32'h0000_0005 at cycle 3 with trc_ready=1 -> trc_valid=1 for one cycle, trc_data={16'd3,5'd8,32'h5}, wr_count=1.
REQ-032 Register 0: wb_en=1, wb_addr=0 for 10 cycles -> trc_valid stays 0 and wr_count=0.
REQ-033 Backpressure: trc_ready=0 with 9 captures on consecutive cycles -> 8 records held, overflow=1, wr_count=9; then trc_ready=1 -> 8 records drain in stamp order, oldest first.
REQ-034 Full plus simultaneous pop: FIFO full, trc_ready=1 and a capture in the same cycle -> occupancy stays 8 and overflow stays 0.
REQ-035 Halt: 5 consecutive instr_s1=0 with no further writes and an empty FIFO -> done=1 four cycles after entering DRAIN; a nonzero instruction after the 4th zero restarts the count.
REQ-036 Reset mid-drain: reset pulsed with 3 records queued -> trc_valid=0 immediately, and after release wr_count=0 and the cycle stamp restarts at 0.
